req_encoder32: RTL and testbench

- Registered priority encoder for the processor's 32-line request/event bus; it is the inverse of the one-hot select decoder.
- Latches request pulses from peripherals (sonar echo, timer, I/O) into a sticky pending vector and presents one winning index to the consumer.
- The consumer (control unit / interrupt logic) takes indices over a valid/ready handshake.
- Accepting an index clears only that pending bit.

---
 rtl/req_enc_pkg.sv | 21 ++
 rtl/req_encoder32_prio_pick.sv | 60 ++++++
 rtl/req_encoder32.sv | 182 ++++++++++++++++++
 tb/tb_req_encoder32.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/req_enc_pkg.sv
// ---------------------------------------------------------------------------
// req_enc_pkg
// Shared definitions for the 32-line request encoder.
//   REQ_W       : default number of request lines
//   REQ_IDX_W   : width of an encoded request index for REQ_W lines
//   req_vec_t   : one bit per request line
//   enc_state_t : presentation FSM states (idle / index presented)
// ---------------------------------------------------------------------------
package req_enc_pkg;

    localparam int REQ_W     = 32;
    localparam int REQ_IDX_W = 5;

    typedef logic [REQ_W-1:0] req_vec_t;

    typedef enum logic {
        ENC_IDLE,
        ENC_PRESENT
    } enc_state_t;

endpackage

// File: rtl/req_encoder32_prio_pick.sv
// ---------------------------------------------------------------------------
// prio_pick
// Purely combinational selection stage: finds the first set bit of vec,
// searching upward from line `start` and wrapping modulo WIDTH.
// With start tied to zero this is a plain lowest-set-bit picker.
//
// Ports:
//   vec    in  WIDTH  candidate lines
//   start  in  IDX_W  line at which the search begins (highest priority)
//   found  out 1      at least one bit of vec is set
//   idx    out IDX_W  index of the winning line (don't care when !found)
//   onehot out WIDTH  one-hot form of idx, all zeros when !found
//
// WIDTH must be a power of two so that IDX_W-bit arithmetic wraps exactly
// at WIDTH.
// ---------------------------------------------------------------------------
module prio_pick #(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] onehot
);

    logic [WIDTH-1:0] rotated;
    logic [IDX_W-1:0] rel_idx;

    // Rotate so that line `start` lands at position 0; the IDX_W-bit sum
    // wraps naturally, giving the modulo-WIDTH search order.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rot
            assign rotated[gi] = vec[IDX_W'(gi) + start];
        end
    endgenerate

    assign found = |rotated;

    // Scanning from the top down leaves the lowest set position in rel_idx.
    always_comb begin
        rel_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                rel_idx = IDX_W'(i);
            end
        end
    end

    // Undo the rotation to get the absolute line number.
    assign idx = rel_idx + start;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_onehot
            assign onehot[gi] = found && (idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/req_encoder32.sv
// ---------------------------------------------------------------------------
// req_encoder32
// Registered priority encoder for the 32-line request/event bus. Request
// pulses are latched into a sticky pending vector; one winning line is
// presented to the consumer as a binary index plus its one-hot form over a
// valid/ready handshake. Accepting an index clears only that pending bit.
//
// Ports:
//   clock    in  1      system clock, rising edge
//   reset_n  in  1      asynchronous active-low reset
//   req      in  WIDTH  request pulses, each high bit sets its pending bit
//   mask     in  WIDTH  1 = line eligible for selection (masked lines pend)
//   ready    in  1      consumer takes the presented index this cycle
//   clr_ovf  in  1      synchronous clear of overflow
//   valid    out 1      index/onehot hold a winning request
//   index    out IDX_W  binary index of the presented request
//   onehot   out WIDTH  one-hot form of index, zero when valid=0
//   pending  out WIDTH  sticky pending vector
//   overflow out 1      sticky: a request hit a line that was still pending
//
// Build option:
//   REQ_ENC_ROUND_ROBIN_EN  when defined, the search starts at a rotating
//                           pointer that moves to index+1 on every accept;
//                           when undefined, lowest index always wins.
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module req_encoder32
    import req_enc_pkg::*;
#(
    parameter int WIDTH = REQ_W
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           req,
    input  logic [WIDTH-1:0]           mask,
    input  logic                       ready,
    input  logic                       clr_ovf,
    output logic                       valid,
    output logic [$clog2(WIDTH)-1:0]   index,
    output logic [WIDTH-1:0]           onehot,
    output logic [WIDTH-1:0]           pending,
    output logic                       overflow
);

    localparam int IDX_W = $clog2(WIDTH);

    enc_state_t       state_reg;
    logic             valid_reg;
    logic [IDX_W-1:0] index_reg;
    logic [WIDTH-1:0] onehot_reg;
    logic [WIDTH-1:0] pending_reg;
    logic [WIDTH-1:0] pending_next;
    logic             ovf_reg;
    logic             ovf_next;

    logic             accept;
    logic [WIDTH-1:0] accept_mask;
    logic [WIDTH-1:0] ovf_hit;
    logic [WIDTH-1:0] elig;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] pick_start;
    logic [WIDTH-1:0] pick_onehot;

    // ------------------------------------------------------------------
    // Handshake and pending-vector bookkeeping
    // ------------------------------------------------------------------
    assign accept      = valid_reg & ready;
    assign accept_mask = accept ? onehot_reg : '0;

    // Per line: a new request always wins over the accept-clear, and a
    // request that lands on a line that stays pending is an overflow.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_line
            assign pending_next[gi] = (pending_reg[gi] & ~accept_mask[gi]) | req[gi];
            assign ovf_hit[gi]      = req[gi] & pending_reg[gi] & ~accept_mask[gi];
            assign elig[gi]         = pending_reg[gi] & mask[gi] & ~accept_mask[gi];
        end
    endgenerate

    // Set wins over clr_ovf in the same cycle.
    assign ovf_next = (|ovf_hit) | (ovf_reg & ~clr_ovf);

    // ------------------------------------------------------------------
    // Search start point
    // ------------------------------------------------------------------
`ifdef REQ_ENC_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_reg;
    logic [IDX_W-1:0] rr_next;

    // The pointer moves only on an accept; the reload that happens in the
    // same cycle already searches from the updated pointer.
    assign rr_next    = accept ? (index_reg + IDX_W'(1)) : rr_reg;
    assign pick_start = rr_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_reg <= '0;
        end else begin
            rr_reg <= rr_next;
        end
    end
`else
    assign pick_start = '0;
`endif

    prio_pick #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_pick (
        .vec    (elig),
        .start  (pick_start),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // ------------------------------------------------------------------
    // Pending vector and overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_reg <= '0;
            ovf_reg     <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            ovf_reg     <= ovf_next;
        end
    end

    // ------------------------------------------------------------------
    // Presentation FSM. Once an index is presented it is held, even if
    // its line gets masked, until the consumer takes it.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ENC_IDLE;
            valid_reg  <= 1'b0;
            index_reg  <= '0;
            onehot_reg <= '0;
        end else begin
            case (state_reg)
                ENC_IDLE: begin
                    if (pick_found) begin
                        state_reg  <= ENC_PRESENT;
                        valid_reg  <= 1'b1;
                        index_reg  <= pick_idx;
                        onehot_reg <= pick_onehot;
                    end
                end
                ENC_PRESENT: begin
                    if (ready) begin
                        if (pick_found) begin
                            // Back-to-back: next winner loaded in the
                            // same edge that retires the current one.
                            index_reg  <= pick_idx;
                            onehot_reg <= pick_onehot;
                        end else begin
                            state_reg  <= ENC_IDLE;
                            valid_reg  <= 1'b0;
                            onehot_reg <= '0;
                        end
                    end
                end
                default: begin
                    state_reg  <= ENC_IDLE;
                    valid_reg  <= 1'b0;
                    onehot_reg <= '0;
                end
            endcase
        end
    end

    assign valid    = valid_reg;
    assign index    = index_reg;
    assign onehot   = onehot_reg;
    assign pending  = pending_reg;
    assign overflow = ovf_reg;

endmodule

// File: tb/tb_req_encoder32.sv
// ---------------------------------------------------------------------------
// tb_req_encoder32
// Self-checking bench for req_encoder32: a table of directed cycles with
// hand-derived expectations, a randomized run against a behavioural model,
// a held-request sequence and an asynchronous reset in mid-handshake.
// Define REQ_ENC_ROUND_ROBIN_EN for both bench and RTL to test that build.
// ---------------------------------------------------------------------------
module tb_req_encoder32;

    localparam int W = 32;
    localparam logic [31:0] ALL = 32'hFFFF_FFFF;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] req = '0;
    logic [31:0] mask = '0;
    logic        ready = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        valid;
    logic [4:0]  index;
    logic [31:0] onehot;
    logic [31:0] pending;
    logic        overflow;

    int passed = 0;
    int total  = 0;

    // Behavioural model state
    bit          m_valid;
    int          m_index;
    logic [31:0] m_pending;
    bit          m_ovf;
    int          m_rr;

    typedef struct {
        logic [31:0] req;
        logic [31:0] mask;
        logic        ready;
        logic        clr;
        logic        exp_valid;
        int          exp_index;
        logic [31:0] exp_pending;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl[$];

    always #5 clock = ~clock;

    req_encoder32 dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req      (req),
        .mask     (mask),
        .ready    (ready),
        .clr_ovf  (clr_ovf),
        .valid    (valid),
        .index    (index),
        .onehot   (onehot),
        .pending  (pending),
        .overflow (overflow)
    );

    function automatic vec_t mk(logic [31:0] r, logic [31:0] m, logic rdy, logic c,
                                logic ev, int ei, logic [31:0] ep, logic eo);
        vec_t v;
        v.req = r; v.mask = m; v.ready = rdy; v.clr = c;
        v.exp_valid = ev; v.exp_index = ei; v.exp_pending = ep; v.exp_ovf = eo;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        m_valid = 0; m_index = 0; m_pending = '0; m_ovf = 0; m_rr = 0;
    endtask

    // One clock edge of the encoder described at line level: which line is
    // being retired, what stays pending, and who wins the next search.
    task automatic model_update(input logic [31:0] r, input logic [31:0] m,
                                input logic rdy, input logic clr);
        int acc_line;
        int start;
        int found_line;
        int l;
        bit hit;
        bit keep;
        logic [31:0] np;
        acc_line = (m_valid && rdy) ? m_index : -1;
        hit = 0;
        for (int k = 0; k < W; k++) begin
            keep = m_pending[k] && (k != acc_line);
            if (r[k] && keep) hit = 1;
            np[k] = keep || r[k];
        end
        start = 0;
`ifdef REQ_ENC_ROUND_ROBIN_EN
        start = (acc_line >= 0) ? (acc_line + 1) % W : m_rr;
`endif
        if (!m_valid || rdy) begin
            found_line = -1;
            for (int k = 0; k < W; k++) begin
                l = (start + k) % W;
                if (found_line < 0 && m_pending[l] && m[l] && l != acc_line) found_line = l;
            end
            m_valid = (found_line >= 0);
            if (found_line >= 0) m_index = found_line;
        end
`ifdef REQ_ENC_ROUND_ROBIN_EN
        if (acc_line >= 0) m_rr = (acc_line + 1) % W;
`endif
        m_ovf = hit || (m_ovf && !clr);
        m_pending = np;
    endtask

    task automatic step(input logic [31:0] r, input logic [31:0] m,
                        input logic rdy, input logic clr);
        req = r; mask = m; ready = rdy; clr_ovf = clr;
        @(posedge clock);
        model_update(r, m, rdy, clr);
        #1;
    endtask

    task automatic compare_model(input string tag);
        logic [31:0] exp_oh;
        exp_oh = m_valid ? (32'h1 << m_index) : 32'h0;
        check({tag, ".valid"}, 32'(valid), 32'(m_valid));
        if (m_valid) check({tag, ".index"}, 32'(index), 32'(m_index));
        check({tag, ".onehot"}, onehot, exp_oh);
        check({tag, ".pending"}, pending, m_pending);
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic do_reset();
        req = '0; mask = '0; ready = 1'b0; clr_ovf = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [31:0] exp_oh;
        logic [31:0] r;
        logic [31:0] m;
        logic        rdy;

        // ---- directed table: each row is one clock, expectations after it
        // test 1: two-cycle latency, then held while ready=0
        tbl.push_back(mk(32'h5, ALL, 0, 0, 0, 0, 32'h5, 0));
        tbl.push_back(mk(32'h0, ALL, 0, 0, 1, 0, 32'h5, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(32'h0, ALL, 0, 0, 1, 0, 32'h5, 0));
        // test 2: back-to-back accept 0 then 2
        tbl.push_back(mk(32'h0, ALL, 1, 0, 1, 2, 32'h4, 0));
        tbl.push_back(mk(32'h0, ALL, 1, 0, 0, 0, 32'h0, 0));
        tbl.push_back(mk(32'h0, ALL, 0, 0, 0, 0, 32'h0, 0));
        // test 3: overflow on line 7, set beats clear, lone clear clears
        tbl.push_back(mk(32'h80, ALL, 0, 0, 0, 0, 32'h80, 0));
        tbl.push_back(mk(32'h00, ALL, 0, 0, 1, 7, 32'h80, 0));
        tbl.push_back(mk(32'h00, ALL, 0, 0, 1, 7, 32'h80, 0));
        tbl.push_back(mk(32'h80, ALL, 0, 0, 1, 7, 32'h80, 1));
        tbl.push_back(mk(32'h80, ALL, 0, 1, 1, 7, 32'h80, 1));
        tbl.push_back(mk(32'h00, ALL, 0, 1, 1, 7, 32'h80, 0));
        tbl.push_back(mk(32'h00, ALL, 1, 0, 0, 0, 32'h00, 0));
        // test 4: accept line 4 while it re-requests
        tbl.push_back(mk(32'h10, ALL, 0, 0, 0, 0, 32'h10, 0));
        tbl.push_back(mk(32'h00, ALL, 0, 0, 1, 4, 32'h10, 0));
        tbl.push_back(mk(32'h10, ALL, 1, 0, 0, 0, 32'h10, 0));
        tbl.push_back(mk(32'h00, ALL, 0, 0, 1, 4, 32'h10, 0));
        tbl.push_back(mk(32'h00, ALL, 1, 0, 0, 0, 32'h00, 0));
        // test 5: masked line pends but is not selected until unmasked
        tbl.push_back(mk(32'h1, 32'hFFFF_FFFE, 0, 0, 0, 0, 32'h1, 0));
        tbl.push_back(mk(32'h0, 32'hFFFF_FFFE, 0, 0, 0, 0, 32'h1, 0));
        tbl.push_back(mk(32'h0, 32'hFFFF_FFFE, 0, 0, 0, 0, 32'h1, 0));
        tbl.push_back(mk(32'h0, ALL, 0, 0, 1, 0, 32'h1, 0));
        tbl.push_back(mk(32'h0, ALL, 1, 0, 0, 0, 32'h0, 0));
        // masking the presented line does not withdraw it
        tbl.push_back(mk(32'h6, ALL, 0, 0, 0, 0, 32'h6, 0));
        tbl.push_back(mk(32'h0, ALL, 0, 0, 1, 1, 32'h6, 0));
        tbl.push_back(mk(32'h0, 32'hFFFF_FFFD, 0, 0, 1, 1, 32'h6, 0));
        tbl.push_back(mk(32'h0, 32'hFFFF_FFFD, 1, 0, 1, 2, 32'h4, 0));
        tbl.push_back(mk(32'h0, ALL, 1, 0, 0, 0, 32'h0, 0));

        do_reset();
        check("reset.valid", 32'(valid), 32'h0);
        check("reset.index", 32'(index), 32'h0);
        check("reset.onehot", onehot, 32'h0);
        check("reset.pending", pending, 32'h0);
        check("reset.overflow", 32'(overflow), 32'h0);

        foreach (tbl[i]) begin
            step(tbl[i].req, tbl[i].mask, tbl[i].ready, tbl[i].clr);
            $display("row %0d req=%h mask=%h ready=%0d clr=%0d -> valid=%0d index=%0d pending=%h ovf=%0d",
                     i, tbl[i].req, tbl[i].mask, tbl[i].ready, tbl[i].clr,
                     valid, index, pending, overflow);
            exp_oh = tbl[i].exp_valid ? (32'h1 << tbl[i].exp_index) : 32'h0;
            check($sformatf("row%0d.valid", i), 32'(valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) check($sformatf("row%0d.index", i), 32'(index), 32'(tbl[i].exp_index));
            check($sformatf("row%0d.onehot", i), onehot, exp_oh);
            check($sformatf("row%0d.pending", i), pending, tbl[i].exp_pending);
            check($sformatf("row%0d.overflow", i), 32'(overflow), 32'(tbl[i].exp_ovf));
        end

        // ---- randomized run against the model
        do_reset();
        m = ALL;
        for (int c = 0; c < 500; c++) begin
            if (c % 50 == 25) m = $urandom | $urandom;
            if (c % 50 == 0) m = ALL;
            r = (c % 100 < 70) ? ($urandom & $urandom & $urandom) : 32'h0;
            rdy = ($urandom_range(0, 3) != 0);
            if (valid && rdy) $display("rand cycle %0d accept index %0d", c, index);
            step(r, m, rdy, ($urandom_range(0, 9) == 0));
            compare_model($sformatf("rand%0d", c));
        end

        // ---- request lines 0 and 3 held high, consumer always ready
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (valid) $display("hold cycle %0d accept index %0d", c, index);
            step(32'h9, ALL, 1'b1, 1'b0);
            compare_model($sformatf("hold%0d", c));
        end
        // asynchronous reset in the middle of the handshake
        #2;
        reset_n = 1'b0;
        #1;
        check("areset.valid", 32'(valid), 32'h0);
        check("areset.index", 32'(index), 32'h0);
        check("areset.onehot", onehot, 32'h0);
        check("areset.pending", pending, 32'h0);
        check("areset.overflow", 32'(overflow), 32'h0);
        do_reset();
        check("post_reset.valid", 32'(valid), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
